dma_ctrl: RTL

DMA_CTRL -- requirements
Module: dma_ctrl

---
 rtl/hc8_bus_pkg.sv | 28 ++
 rtl/dma_counter.sv | 44 ++++
 rtl/dma_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/hc8_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hc8_bus_pkg
// Description : Shared HC8 system-bus definitions: bus widths, strobe levels
//               and the DMA controller state encoding. Imported by the DMA
//               controller and by the HC8 core top-level.
// Revision    : 1.0 - initial release
// ============================================================================
package hc8_bus_pkg;

    localparam int c_HC8_ADDR_W = 16;
    localparam int c_HC8_DATA_W = 8;

    // Bus strobes (nDMA_REQ, nRAM_RD, nRAM_WR) are all active-low.
    localparam logic c_STROBE_ON  = 1'b0;
    localparam logic c_STROBE_OFF = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_NEXT  = 3'd4,
        ST_REL   = 3'd5
    } dma_state_t;

endpackage
`default_nettype wire

// File: rtl/dma_counter.sv
`default_nettype none
// ============================================================================
// Module      : dma_counter
// Description : Loadable up/down counter used for the DMA source address,
//               destination address and remaining-length registers. Wraps
//               modulo 2^WIDTH in both directions.
// Ports       : clk, nReset (async, active-low)
//               load / load_val : parallel load (highest priority)
//               inc / dec       : step by one
//               count           : current value
// Revision    : 1.0 - initial release
// ============================================================================
module dma_counter
    import hc8_bus_pkg::*;
#(
    parameter int WIDTH = c_HC8_ADDR_W
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (inc) begin
            r_count <= r_count + WIDTH'(1);
        end else if (dec) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/dma_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dma_ctrl
// Description : Memory-to-memory copy / fill DMA engine for the HC8 bus.
//               Requests the bus with nDMA_REQ, waits for the core to let go,
//               then runs READ/WRITE/NEXT per byte (WRITE/NEXT in fill mode)
//               and releases the bus with a one-cycle done pulse.
// Ports       : clk, nReset (async, active-low)
//               start, cfg_src, cfg_dst, cfg_len, cfg_fill, cfg_value, abort
//               busy, done, nDMA_REQ
//               bus_oe, address_bus, nRAM_RD, nRAM_WR  (address/strobe drive)
//               data_oe, data_out, data_in             (data bus)
// Revision    : 1.0 - initial release
// ============================================================================
module dma_ctrl
    import hc8_bus_pkg::*;
#(
    parameter int ADDR_W     = c_HC8_ADDR_W,
    parameter int DATA_W     = c_HC8_DATA_W,
    parameter int LEN_W      = 16,
    parameter int GRANT_WAIT = 1            // legal range 1..15
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              cfg_fill,
    input  logic [DATA_W-1:0] cfg_value,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              nDMA_REQ,
    output logic              bus_oe,
    output logic [ADDR_W-1:0] address_bus,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in,
    output logic              nRAM_RD,
    output logic              nRAM_WR
);

    dma_state_t        r_state;
    dma_state_t        w_next;
    logic [3:0]        r_wait;
    logic              r_fill;
    logic [DATA_W-1:0] r_value;
    logic [DATA_W-1:0] r_data;
    logic              r_abort_pend;
    logic              r_zero_done;

    logic [ADDR_W-1:0] w_src;
    logic [ADDR_W-1:0] w_dst;
    logic [LEN_W-1:0]  w_len;
    logic              w_accept;
    logic              w_zero;
    logic              w_in_next;
    logic              w_len_last;
    logic              w_wr_en;

    // Starts are only honoured in IDLE, so a start while busy changes nothing.
    assign w_accept   = (r_state == ST_IDLE) && start && (cfg_len != '0);
    assign w_zero     = (r_state == ST_IDLE) && start && (cfg_len == '0);
    assign w_in_next  = (r_state == ST_NEXT);
    // Length decrements at the end of NEXT, so "reaching zero" is len==1 now.
    assign w_len_last = (w_len == LEN_W'(1));

    dma_counter #(.WIDTH(ADDR_W)) u_src_cnt (
        .clk      (clk),
        .nReset   (nReset),
        .load     (w_accept),
        .load_val (cfg_src),
        .inc      (w_in_next && !r_fill),
        .dec      (1'b0),
        .count    (w_src)
    );

    dma_counter #(.WIDTH(ADDR_W)) u_dst_cnt (
        .clk      (clk),
        .nReset   (nReset),
        .load     (w_accept),
        .load_val (cfg_dst),
        .inc      (w_in_next),
        .dec      (1'b0),
        .count    (w_dst)
    );

    dma_counter #(.WIDTH(LEN_W)) u_len_cnt (
        .clk      (clk),
        .nReset   (nReset),
        .load     (w_accept),
        .load_val (cfg_len),
        .inc      (1'b0),
        .dec      (w_in_next),
        .count    (w_len)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The first REQ cycle presents nDMA_REQ; the core samples it at the
    // following edge and frees the bus, after which GRANT_WAIT cycles elapse
    // before the first drive. Hence REQ lasts GRANT_WAIT+1 cycles.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            r_wait       <= 4'd0;
            r_fill       <= 1'b0;
            r_value      <= '0;
            r_data       <= '0;
            r_abort_pend <= 1'b0;
            r_zero_done  <= 1'b0;
        end else begin
            r_zero_done <= w_zero;
            if (w_accept) begin
                r_wait  <= 4'(GRANT_WAIT);
                r_fill  <= cfg_fill;
                r_value <= cfg_value;
            end else if ((r_state == ST_REQ) && (r_wait != 4'd0)) begin
                r_wait <= r_wait - 4'd1;
            end
            if (r_state == ST_READ) begin
                r_data <= data_in;
            end
            // Abort seen mid-byte is remembered so the byte can finish even
            // if abort has dropped again by the time NEXT decides.
            if (r_state == ST_IDLE) begin
                r_abort_pend <= 1'b0;
            end else if (abort && ((r_state == ST_READ) || (r_state == ST_WRITE))) begin
                r_abort_pend <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        nDMA_REQ    = c_STROBE_OFF;
        bus_oe      = 1'b0;
        data_oe     = 1'b0;
        nRAM_RD     = c_STROBE_OFF;
        w_wr_en     = 1'b0;
        address_bus = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_REQ;
                end
            end
            ST_REQ: begin
                nDMA_REQ = c_STROBE_ON;
                if (abort) begin
                    w_next = ST_REL;
                end else if (r_wait == 4'd0) begin
                    w_next = r_fill ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                nDMA_REQ    = c_STROBE_ON;
                bus_oe      = 1'b1;
                address_bus = w_src;
                nRAM_RD     = c_STROBE_ON;
                w_next      = ST_WRITE;
            end
            ST_WRITE: begin
                nDMA_REQ    = c_STROBE_ON;
                bus_oe      = 1'b1;
                data_oe     = 1'b1;
                address_bus = w_dst;
                w_wr_en     = 1'b1;
                w_next      = ST_NEXT;
            end
            ST_NEXT: begin
                nDMA_REQ    = c_STROBE_ON;
                bus_oe      = 1'b1;
                address_bus = w_dst;
                if (w_len_last || r_abort_pend || abort) begin
                    w_next = ST_REL;
                end else begin
                    w_next = r_fill ? ST_WRITE : ST_READ;
                end
            end
            ST_REL: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Write strobe only in the low half of WRITE, matching the core's own
    // gating so address/data are settled before and after the strobe.
    assign nRAM_WR  = (w_wr_en && !clk) ? c_STROBE_ON : c_STROBE_OFF;
    assign data_out = data_oe ? (r_fill ? r_value : r_data) : '0;
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_REL) || r_zero_done;

endmodule
`default_nettype wire
